// File: rtl/io_driver_host.sv
// -----------------------------------------------------------------------------
// io_driver_host
// MCU-side initiator for the FPGA pin-driver command bus. It accepts one local
// command at a time and turns it into a bus transaction:
//   op 1 : SPI bit write  (tx words shifted out on MOSI, LSB first)
//   op 2 : SPI bit read   (MISO collected into rx words, LSB first)
//   op 3..6 : control requests strobed with process_rqst; ops 3..5 then wait
//             for the FPGA to drop and raise req_done again
//   op 0/7 : invalid, answered with an immediate done and no bus activity
//
// Ports
//   s_clk, reset            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (ready only while idle)
//   cmd_op/fpga/addr/len    : command fields, latched on accept
//   tx_data/tx_valid        : write word source; tx_ready pulses one cycle
//                             after the word has been taken
//   rx_data/rx_valid        : read word sink, one-cycle pulse, no backpressure
//   busy, done, timeout_err : status (done is a pulse, timeout_err is sticky
//                             until the next accepted command)
//   SCK/MOSI/MISO           : SPI bit lanes
//   CS_addr/addr/request    : bus select, pin index and request code
//   process_rqst/req_done   : control strobe and FPGA completion flag
//
// All outputs are registered: one combinational block computes the next value
// of every register, one sequential block stores them.
// -----------------------------------------------------------------------------
module io_driver_host #(
    parameter int         SCK_HALF     = 4,
    parameter int         SETUP_CYC    = 4,
    parameter int         PULSE_CYC    = 8,
    parameter int         LOW_WAIT     = 64,
    parameter int         TIMEOUT_CYC  = 65535,
    parameter logic [1:0] IDLE_CS_ADDR = 2'd0
) (
    input  logic        s_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_fpga,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [1:0]  CS_addr,
    output logic [3:0]  addr,
    output logic [2:0]  request,
    output logic        process_rqst,
    input  logic        req_done
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max_of(max_of(max_of(SCK_HALF, SETUP_CYC),
                                           max_of(PULSE_CYC, LOW_WAIT)),
                                    TIMEOUT_CYC);
    localparam int TIMER_W = $clog2(MAX_CYC + 1);

    localparam logic [TIMER_W-1:0] TMR_ZERO   = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TMR_ONE    = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] SCK_LAST   = TIMER_W'(SCK_HALF - 1);
    localparam logic [TIMER_W-1:0] SETUP_LAST = TIMER_W'(SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0] LOW_LAST   = TIMER_W'(LOW_WAIT - 1);
    localparam logic [TIMER_W-1:0] TO_LAST    = TIMER_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_CLKO  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_SCK_LOW   = 3'd2,
        ST_SCK_HIGH  = 3'd3,
        ST_PULSE     = 3'd4,
        ST_WAIT_LOW  = 3'd5,
        ST_WAIT_HIGH = 3'd6,
        ST_HOLD      = 3'd7
    } state_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    state_t               state_r, state_s;
    logic [TIMER_W-1:0]   timer_r, timer_s;
    logic [2:0]           op_r, op_s;
    logic [15:0]          remaining_r, remaining_s;
    logic [3:0]           bit_idx_r, bit_idx_s;
    logic [14:0]          shift_r, shift_s;      // bits still to send after MOSI
    logic [15:0]          rx_word_r, rx_word_s;
    logic                 fetch_pend_r, fetch_pend_s;
    logic                 rd_meta_r, rd_sync_r;

    logic                 cmd_ready_r, cmd_ready_s;
    logic                 tx_ready_r, tx_ready_s;
    logic [15:0]          rx_data_r, rx_data_s;
    logic                 rx_valid_r, rx_valid_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 timeout_err_r, timeout_err_s;
    logic                 sck_r, sck_s;
    logic                 mosi_r, mosi_s;
    logic [1:0]           cs_addr_r, cs_addr_s;
    logic [3:0]           addr_r, addr_s;
    logic [2:0]           request_r, request_s;
    logic                 process_rqst_r, process_rqst_s;

    // Two-stage synchronizer for the FPGA completion flag; idles high.
    always_ff @(posedge s_clk or posedge reset) begin
        if (reset) begin
            rd_meta_r <= 1'b1;
            rd_sync_r <= 1'b1;
        end else begin
            rd_meta_r <= req_done;
            rd_sync_r <= rd_meta_r;
        end
    end

    // Next-state and next-output computation for the whole transaction FSM.
    always_comb begin
        state_s        = state_r;
        timer_s        = timer_r + TMR_ONE;
        op_s           = op_r;
        remaining_s    = remaining_r;
        bit_idx_s      = bit_idx_r;
        shift_s        = shift_r;
        rx_word_s      = rx_word_r;
        fetch_pend_s   = fetch_pend_r;
        tx_ready_s     = 1'b0;
        rx_data_s      = rx_data_r;
        rx_valid_s     = 1'b0;
        done_s         = 1'b0;
        timeout_err_s  = timeout_err_r;
        sck_s          = sck_r;
        mosi_s         = mosi_r;
        cs_addr_s      = cs_addr_r;
        addr_s         = addr_r;
        request_s      = request_r;
        process_rqst_s = process_rqst_r;

        case (state_r)
            ST_IDLE: begin
                timer_s = TMR_ZERO;
                if (cmd_valid && cmd_ready_r) begin
                    timeout_err_s = 1'b0;
                    op_s          = cmd_op;
                    remaining_s   = cmd_len;
                    bit_idx_s     = 4'd0;
                    shift_s       = 15'd0;
                    rx_word_s     = 16'd0;
                    fetch_pend_s  = 1'b0;
                    if (op_is_valid(cmd_op)) begin
                        state_s   = ST_SETUP;
                        cs_addr_s = cmd_fpga;
                        addr_s    = cmd_addr;
                        request_s = cmd_op;
                    end else begin
                        // Invalid op: answer at once, never touch the bus.
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (timer_r == SETUP_LAST) begin
                    timer_s = TMR_ZERO;
                    if ((op_r == OP_WRITE) || (op_r == OP_READ)) begin
                        if (remaining_r == 16'd0) begin
                            state_s = ST_HOLD;
                        end else begin
                            state_s      = ST_SCK_LOW;
                            fetch_pend_s = (op_r == OP_WRITE);
                        end
                    end else begin
                        state_s        = ST_PULSE;
                        process_rqst_s = 1'b1;
                    end
                end else begin
                    state_s = ST_SETUP;
                end
            end

            ST_SCK_LOW: begin
                if (fetch_pend_r) begin
                    // Word boundary: the low phase only starts once a word
                    // is in hand; SCK simply stays low while we wait.
                    timer_s = timer_r;
                    if (tx_valid) begin
                        tx_ready_s   = 1'b1;
                        mosi_s       = tx_data[0];
                        shift_s      = tx_data[15:1];
                        fetch_pend_s = 1'b0;
                        timer_s      = TMR_ZERO;
                    end else begin
                        fetch_pend_s = 1'b1;
                    end
                end else if (timer_r == SCK_LAST) begin
                    state_s = ST_SCK_HIGH;
                    sck_s   = 1'b1;
                    timer_s = TMR_ZERO;
                end else begin
                    state_s = ST_SCK_LOW;
                end
            end

            ST_SCK_HIGH: begin
                if (timer_r == SCK_LAST) begin
                    timer_s     = TMR_ZERO;
                    sck_s       = 1'b0;
                    remaining_s = remaining_r - 16'd1;
                    bit_idx_s   = bit_idx_r + 4'd1;
                    if (op_r == OP_READ) begin
                        // The FPGA updates its data on our rising edge, so
                        // the end of the high phase is the safest sample point.
                        rx_word_s[bit_idx_r] = MISO;
                        if ((bit_idx_r == 4'd15) || (remaining_r == 16'd1)) begin
                            rx_valid_s = 1'b1;
                            rx_data_s  = rx_word_s;
                            rx_word_s  = 16'd0;
                        end else begin
                            rx_valid_s = 1'b0;
                        end
                    end else begin
                        rx_valid_s = 1'b0;
                    end
                    if (remaining_r == 16'd1) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_SCK_LOW;
                        if (op_r == OP_WRITE) begin
                            mosi_s       = shift_r[0];
                            shift_s      = {1'b0, shift_r[14:1]};
                            fetch_pend_s = (bit_idx_r == 4'd15);
                        end else begin
                            mosi_s = 1'b0;
                        end
                    end
                end else begin
                    state_s = ST_SCK_HIGH;
                end
            end

            ST_PULSE: begin
                if (timer_r == PULSE_LAST) begin
                    timer_s        = TMR_ZERO;
                    process_rqst_s = 1'b0;
                    // Clock output has no completion handshake.
                    state_s        = (op_r == OP_CLKO) ? ST_HOLD : ST_WAIT_LOW;
                end else begin
                    state_s = ST_PULSE;
                end
            end

            ST_WAIT_LOW: begin
                // A very short request may finish before the low level is
                // ever seen; running out the window is therefore not an error.
                if ((rd_sync_r == 1'b0) || (timer_r == LOW_LAST)) begin
                    state_s = ST_WAIT_HIGH;
                    timer_s = TMR_ZERO;
                end else begin
                    state_s = ST_WAIT_LOW;
                end
            end

            ST_WAIT_HIGH: begin
                if (rd_sync_r == 1'b1) begin
                    state_s = ST_HOLD;
                    timer_s = TMR_ZERO;
                end else if (timer_r == TO_LAST) begin
                    state_s       = ST_HOLD;
                    timer_s       = TMR_ZERO;
                    timeout_err_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_HIGH;
                end
            end

            ST_HOLD: begin
                if (timer_r == SETUP_LAST) begin
                    state_s   = ST_IDLE;
                    timer_s   = TMR_ZERO;
                    cs_addr_s = IDLE_CS_ADDR;
                    request_s = 3'd0;
                    mosi_s    = 1'b0;
                    done_s    = 1'b1;
                end else begin
                    state_s = ST_HOLD;
                end
            end

            default: begin
                state_s        = ST_IDLE;
                timer_s        = TMR_ZERO;
                sck_s          = 1'b0;
                mosi_s         = 1'b0;
                cs_addr_s      = IDLE_CS_ADDR;
                request_s      = 3'd0;
                process_rqst_s = 1'b0;
            end
        endcase

        busy_s      = (state_s != ST_IDLE);
        cmd_ready_s = (state_s == ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge s_clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            timer_r        <= TMR_ZERO;
            op_r           <= 3'd0;
            remaining_r    <= 16'd0;
            bit_idx_r      <= 4'd0;
            shift_r        <= 15'd0;
            rx_word_r      <= 16'd0;
            fetch_pend_r   <= 1'b0;
            cmd_ready_r    <= 1'b1;
            tx_ready_r     <= 1'b0;
            rx_data_r      <= 16'd0;
            rx_valid_r     <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            timeout_err_r  <= 1'b0;
            sck_r          <= 1'b0;
            mosi_r         <= 1'b0;
            cs_addr_r      <= IDLE_CS_ADDR;
            addr_r         <= 4'd0;
            request_r      <= 3'd0;
            process_rqst_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            timer_r        <= timer_s;
            op_r           <= op_s;
            remaining_r    <= remaining_s;
            bit_idx_r      <= bit_idx_s;
            shift_r        <= shift_s;
            rx_word_r      <= rx_word_s;
            fetch_pend_r   <= fetch_pend_s;
            cmd_ready_r    <= cmd_ready_s;
            tx_ready_r     <= tx_ready_s;
            rx_data_r      <= rx_data_s;
            rx_valid_r     <= rx_valid_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            timeout_err_r  <= timeout_err_s;
            sck_r          <= sck_s;
            mosi_r         <= mosi_s;
            cs_addr_r      <= cs_addr_s;
            addr_r         <= addr_s;
            request_r      <= request_s;
            process_rqst_r <= process_rqst_s;
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign tx_ready     = tx_ready_r;
    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign timeout_err  = timeout_err_r;
    assign SCK          = sck_r;
    assign MOSI         = mosi_r;
    assign CS_addr      = cs_addr_r;
    assign addr         = addr_r;
    assign request      = request_r;
    assign process_rqst = process_rqst_r;

endmodule

// File: tb/tb_io_driver_host.sv
// -----------------------------------------------------------------------------
// tb_io_driver_host
// Directed bench for io_driver_host: write, read, stalled write, control
// request with handshake, timeout, invalid op, reset mid-read, clock output.
// A negedge monitor counts bus events and plays the tx source / MISO model.
// -----------------------------------------------------------------------------
module tb_io_driver_host;

    localparam int SCK_HALF    = 4;
    localparam int SETUP_CYC   = 4;
    localparam int PULSE_CYC   = 8;
    localparam int LOW_WAIT    = 64;
    localparam int TIMEOUT_CYC = 1000;

    logic        s_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_fpga;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_len;
    logic [15:0] tx_data = 16'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        SCK;
    logic        MOSI;
    logic        MISO = 1'b0;
    logic [1:0]  CS_addr;
    logic [3:0]  addr;
    logic [2:0]  request;
    logic        process_rqst;
    logic        req_done;

    io_driver_host #(
        .SCK_HALF    (SCK_HALF),
        .SETUP_CYC   (SETUP_CYC),
        .PULSE_CYC   (PULSE_CYC),
        .LOW_WAIT    (LOW_WAIT),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .IDLE_CS_ADDR(2'd0)
    ) dut (
        .s_clk(s_clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_fpga(cmd_fpga), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .timeout_err(timeout_err), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .CS_addr(CS_addr), .addr(addr), .request(request),
        .process_rqst(process_rqst), .req_done(req_done)
    );

    always #5 s_clk = ~s_clk;

    int n_cmp = 0;
    int n_err = 0;

    // monitor state
    int          cyc = 0;
    int          rise_cnt = 0;
    int          rise_cyc [256];
    logic        mosi_bits [256];
    int          hi_cnt = 0;
    int          tx_pops = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          prq_cnt = 0;
    int          prq_rise_cyc = 0;
    logic        prq_q = 1'b0;
    logic        sck_q = 1'b0;
    logic [15:0] rx_log [16];
    int          rx_cnt = 0;
    int          bus_err = 0;
    int          stall_cnt = 0;

    // control from the main sequence
    logic [2:0]  mon_req = 3'd0;
    logic [1:0]  mon_cs = 2'd0;
    logic [15:0] tx_words [4];
    int          tx_base = 0;
    int          tx_n = 0;
    logic [31:0] miso_pat = 32'd0;
    int          miso_base = 0;
    int          rise_base = 0;
    logic        stall_en = 1'b0;

    always @(posedge s_clk) cyc++;

    // Event monitor plus tx word source and MISO responder.
    always @(negedge s_clk) begin
        int mi;
        int ti;
        if (SCK && !sck_q) begin
            rise_cyc[rise_cnt & 255]  = cyc;
            mosi_bits[rise_cnt & 255] = MOSI;
            mi = rise_cnt - miso_base;
            MISO = (mi >= 0 && mi < 32) ? miso_pat[mi] : 1'b0;
            rise_cnt++;
        end
        sck_q = SCK;
        if (SCK) hi_cnt++;
        if (tx_ready) tx_pops++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (process_rqst) prq_cnt++;
        if (process_rqst && !prq_q) prq_rise_cyc = cyc;
        prq_q = process_rqst;
        if (rx_valid) begin
            rx_log[rx_cnt & 15] = rx_data;
            rx_cnt++;
        end
        if (busy && ((request != mon_req) || (CS_addr != mon_cs))) bus_err++;
        ti = tx_pops - tx_base;
        if (stall_en && ti == 1 && stall_cnt < 50) begin
            tx_valid = 1'b0;
            if (rise_cnt - rise_base >= 16) stall_cnt++;
        end else begin
            tx_valid = (ti < tx_n);
            tx_data  = tx_words[(ti >= 0 && ti < 4) ? ti : 0];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge s_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] fpga,
                            input logic [3:0] a, input logic [15:0] len);
        tick();
        cmd_op = op; cmd_fpga = fpga; cmd_addr = a; cmd_len = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        check_eq(tag, done_cnt - d0, 1);
    endtask

    function automatic logic [17:0] out_vec();
        return {SCK, MOSI, CS_addr, addr, request, process_rqst, busy, done,
                rx_valid, tx_ready, timeout_err, cmd_ready};
    endfunction

    initial begin
        int r0, x0, p0, d0, rd_cyc;
        logic [31:0] obs;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_fpga = 2'd0;
        cmd_addr = 4'd0; cmd_len = 16'd0; req_done = 1'b1;
        tx_words[0] = 16'd0; tx_words[1] = 16'd0; tx_words[2] = 16'd0; tx_words[3] = 16'd0;
        repeat (3) tick();
        check_eq("reset_outputs", 32'(out_vec()), 32'd1);
        reset = 1'b0;
        repeat (2) tick();

        // ---- write: 20 bits from 0xA5C3, 0x000F
        mon_req = 3'd1; mon_cs = 2'd2;
        tx_words[0] = 16'hA5C3; tx_words[1] = 16'h000F;
        tx_base = tx_pops; tx_n = 2; r0 = rise_cnt; x0 = tx_pops;
        send_cmd(3'd1, 2'd2, 4'd5, 16'd20);
        wait_done(2000, "wr_done");
        check_eq("wr_rises", rise_cnt - r0, 20);
        obs = 32'd0;
        for (int i = 0; i < 20; i++) obs[i] = mosi_bits[(r0 + i) & 255];
        check_eq("wr_mosi_bits", obs, 32'h000FA5C3);
        check_eq("wr_tx_ready", tx_pops - x0, 2);
        check_eq("wr_idle_bus", {CS_addr, request, MOSI, SCK}, 32'd0);

        // ---- read: 18 bits, MISO pattern 0x3_1234
        mon_req = 3'd2; mon_cs = 2'd1;
        tx_base = tx_pops; tx_n = 0;
        miso_base = rise_cnt; miso_pat = 32'h0003_1234; r0 = rise_cnt; x0 = rx_cnt;
        send_cmd(3'd2, 2'd1, 4'd3, 16'd18);
        wait_done(2000, "rd_done");
        check_eq("rd_rises", rise_cnt - r0, 18);
        check_eq("rd_words", rx_cnt - x0, 2);
        check_eq("rd_word0", rx_log[x0 & 15], 32'h1234);
        check_eq("rd_word1", rx_log[(x0 + 1) & 15], 32'h0003);

        // ---- stalled write: len 32, second word held back at bit 16
        mon_req = 3'd1; mon_cs = 2'd3;
        tx_words[0] = 16'h1234; tx_words[1] = 16'hABCD;
        rise_base = rise_cnt; stall_en = 1'b1;
        tx_base = tx_pops; tx_n = 2; r0 = rise_cnt; x0 = tx_pops; p0 = hi_cnt;
        send_cmd(3'd1, 2'd3, 4'd9, 16'd32);
        wait_done(3000, "st_done");
        stall_en = 1'b0;
        check_eq("st_rises", rise_cnt - r0, 32);
        check_eq("st_high_cycles", hi_cnt - p0, 32 * SCK_HALF);
        check_eq("st_gap_ge50", 32'((rise_cyc[(r0 + 16) & 255] - rise_cyc[(r0 + 15) & 255]) >= 50), 32'd1);
        obs = 32'd0;
        for (int i = 0; i < 32; i++) obs[i] = mosi_bits[(r0 + i) & 255];
        check_eq("st_mosi_bits", obs, 32'hABCD1234);
        check_eq("st_tx_ready", tx_pops - x0, 2);

        // ---- control op3 with req_done handshake
        mon_req = 3'd3; mon_cs = 2'd2;
        tx_n = 0; tx_base = tx_pops; p0 = prq_cnt;
        send_cmd(3'd3, 2'd2, 4'd1, 16'd0);
        for (int i = 0; i < 100 && prq_cnt == p0; i++) tick();
        check_eq("ctl_pulse_seen", 32'(prq_cnt != p0), 32'd1);
        repeat (10) tick();
        req_done = 1'b0;
        repeat (200) tick();
        req_done = 1'b1;
        rd_cyc = cyc;
        wait_done(500, "ctl_done");
        check_eq("ctl_pulse_len", prq_cnt - p0, PULSE_CYC);
        check_eq("ctl_done_lat", done_cyc - rd_cyc, 3 + SETUP_CYC);
        check_eq("ctl_timeout_err", timeout_err, 32'd0);

        // ---- timeout on op5
        mon_req = 3'd5; mon_cs = 2'd1;
        req_done = 1'b0;
        send_cmd(3'd5, 2'd1, 4'd2, 16'd0);
        wait_done(3000, "to_done");
        check_eq("to_err_set", timeout_err, 32'd1);
        check_eq("to_done_lat", done_cyc - prq_rise_cyc, PULSE_CYC + 1 + TIMEOUT_CYC + SETUP_CYC);
        check_eq("to_cs_idle", CS_addr, 32'd0);
        req_done = 1'b1;

        // ---- invalid op: immediate done, clears timeout_err, no bus
        d0 = done_cnt;
        send_cmd(3'd7, 2'd3, 4'd4, 16'd8);
        check_eq("inv_done_err_cs_busy", {done, timeout_err, CS_addr, busy}, 32'b10000);
        tick();
        check_eq("inv_done_once", done_cnt - d0, 1);

        // ---- reset in the middle of a read
        mon_req = 3'd2; mon_cs = 2'd1;
        r0 = rise_cnt; miso_base = rise_cnt; miso_pat = 32'h0000_00FF;
        send_cmd(3'd2, 2'd1, 4'd5, 16'd16);
        for (int i = 0; i < 500 && (rise_cnt - r0) < 8; i++) tick();
        check_eq("rst_reached_bit7", rise_cnt - r0, 8);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_outputs", 32'(out_vec()), 32'd1);
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        check_eq("rst_no_done", done_cnt - d0, 0);
        check_eq("rst_cmd_ready", cmd_ready, 32'd1);

        // ---- clock output op6: single pulse, no handshake
        mon_req = 3'd6; mon_cs = 2'd1;
        req_done = 1'b0;
        p0 = prq_cnt;
        send_cmd(3'd6, 2'd1, 4'd4, 16'd0);
        wait_done(500, "clk_done");
        check_eq("clk_pulse_len", prq_cnt - p0, PULSE_CYC);
        check_eq("clk_done_lat", done_cyc - prq_rise_cyc, PULSE_CYC + SETUP_CYC);
        check_eq("clk_timeout_err", timeout_err, 32'd0);

        check_eq("bus_fields_stable", bus_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
